// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/kill bundle and decode-side results of the register scoreboard
interface reg_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int KILL_PORTS = 2
);
  logic                         issue_valid_i;
  logic [ADDR_W-1:0]            issue_rs1_i;
  logic [ADDR_W-1:0]            issue_rs2_i;
  logic                         issue_use_rs1_i;
  logic                         issue_use_rs2_i;
  logic [ADDR_W-1:0]            issue_rd_i;
  logic                         issue_we_i;
  logic                         wb_valid_i;
  logic [ADDR_W-1:0]            wb_rd_i;
  logic                         wb_we_i;
  logic [KILL_PORTS-1:0]        kill_valid_i;
  logic [KILL_PORTS*ADDR_W-1:0] kill_rd_i;
  logic [KILL_PORTS-1:0]        kill_we_i;
  logic                         stall_o;
  logic                         issue_fire_o;
  logic [NUM_REGS-1:0]          busy_o;
  logic                         underflow_o;

  // Pipeline side: drives issue/writeback/kill events, consumes stall and status
  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
    output issue_rd_i, issue_we_i, wb_valid_i, wb_rd_i, wb_we_i,
    output kill_valid_i, kill_rd_i, kill_we_i,
    input  stall_o, issue_fire_o, busy_o, underflow_o
  );

  // Scoreboard side
  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
    input  issue_rd_i, issue_we_i, wb_valid_i, wb_rd_i, wb_we_i,
    input  kill_valid_i, kill_rd_i, kill_we_i,
    output stall_o, issue_fire_o, busy_o, underflow_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters driving the decode stall
module reg_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int CNT_W      = 2,
  parameter int KILL_PORTS = 2,
  parameter int WB_BYPASS  = 1
) (
  input logic             clk_i,
  input logic             rstn_i,
  reg_scoreboard_if.slave bus
);
  // Wide enough for counter + one increment and for up to KILL_PORTS+1 decrements
  localparam int DEC_W = $clog2(KILL_PORTS + 2);
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic [SUM_W-1:0]  dec   [NUM_REGS];
  logic              underflow_q;
  logic              underflow_d;

  logic              wb_ev;
  logic [KILL_PORTS-1:0] kill_ev;
  logic [ADDR_W-1:0] kill_rd [KILL_PORTS];

  logic [CNT_W-1:0]  cnt_rs1;
  logic [CNT_W-1:0]  cnt_rs2;
  logic [CNT_W-1:0]  cnt_rd;
  logic              byp_rs1;
  logic              byp_rs2;
  logic              hz_rs1;
  logic              hz_rs2;
  logic              sat;
  logic              fire;
  logic [SUM_W-1:0]  inc_v;
  logic [SUM_W-1:0]  avail;

  // Writes to register 0 are never tracked, so such events are dropped here
  assign wb_ev = bus.wb_valid_i & bus.wb_we_i & (bus.wb_rd_i != '0);

  // Unpack kill lanes and qualify each one
  always_comb begin
    kill_ev = '0;
    for (int k = 0; k < KILL_PORTS; k++) begin
      kill_rd[k] = bus.kill_rd_i[k*ADDR_W +: ADDR_W];
      kill_ev[k] = bus.kill_valid_i[k] & bus.kill_we_i[k] & (kill_rd[k] != '0);
    end
  end

  // Count decrement events (writeback plus kill lanes) landing on each register
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = '0;
      if (r != 0) begin
        if (wb_ev && (bus.wb_rd_i == ADDR_W'(r))) dec[r] = dec[r] + SUM_W'(1);
        for (int k = 0; k < KILL_PORTS; k++) begin
          if (kill_ev[k] && (kill_rd[k] == ADDR_W'(r))) dec[r] = dec[r] + SUM_W'(1);
        end
      end
    end
  end

  assign cnt_rs1 = cnt_q[bus.issue_rs1_i];
  assign cnt_rs2 = cnt_q[bus.issue_rs2_i];
  assign cnt_rd  = cnt_q[bus.issue_rd_i];

  // Only the retiring writeback can forward through the regfile; a killed writer
  // produces no value, so kills never clear a hazard.
  assign byp_rs1 = (WB_BYPASS != 0) & (cnt_rs1 == CNT_W'(1)) & wb_ev & (bus.wb_rd_i == bus.issue_rs1_i);
  assign byp_rs2 = (WB_BYPASS != 0) & (cnt_rs2 == CNT_W'(1)) & wb_ev & (bus.wb_rd_i == bus.issue_rs2_i);

  assign hz_rs1 = bus.issue_use_rs1_i & (bus.issue_rs1_i != '0) & (cnt_rs1 != '0) & ~byp_rs1;
  assign hz_rs2 = bus.issue_use_rs2_i & (bus.issue_rs2_i != '0) & (cnt_rs2 != '0) & ~byp_rs2;

  // A full counter only blocks a new writer if nothing retires from it this cycle
  assign sat = bus.issue_we_i & (bus.issue_rd_i != '0) & (cnt_rd == CNT_MAX) &
               (dec[bus.issue_rd_i] == '0);

  assign bus.stall_o      = bus.issue_valid_i & (hz_rs1 | hz_rs2 | sat);
  assign fire             = bus.issue_valid_i & ~bus.stall_o;
  assign bus.issue_fire_o = fire;
  assign bus.underflow_o  = underflow_q;

  // Next counter values: add accepted issue, subtract retirements, clamp at zero on underflow
  always_comb begin
    underflow_d = underflow_q;
    inc_v       = '0;
    avail       = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
      if (r != 0) begin
        inc_v = (fire && bus.issue_we_i && (bus.issue_rd_i == ADDR_W'(r))) ? SUM_W'(1) : '0;
        avail = SUM_W'(cnt_q[r]) + inc_v;
        if (dec[r] > avail) begin
          cnt_d[r]    = '0;
          underflow_d = 1'b1;
        end else begin
          cnt_d[r] = CNT_W'(avail - dec[r]);
        end
      end
    end
  end

  // Counter and sticky error state, cleared asynchronously
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      underflow_q <= underflow_d;
    end
  end

  // Busy map straight from registered counters
  always_comb begin
    bus.busy_o = '0;
    for (int r = 0; r < NUM_REGS; r++) bus.busy_o[r] = (cnt_q[r] != '0);
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed test of reg_scoreboard
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5), .KILL_PORTS(2)) sb();

  reg_scoreboard #(
    .NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .KILL_PORTS(2), .WB_BYPASS(1)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (sb)
  );

  typedef struct {
    string       nm;
    logic        stall;
    logic        fire;
    logic [31:0] busy;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string nm, string f, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  // Monitor: pop the expectation for this cycle and compare away from the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.nm, "stall", 32'(sb.stall_o), 32'(e.stall));
      chk(e.nm, "fire", 32'(sb.issue_fire_o), 32'(e.fire));
      chk(e.nm, "busy", sb.busy_o, e.busy);
      chk(e.nm, "underflow", 32'(sb.underflow_o), 32'(e.uf));
    end
  end

  task automatic idle();
    sb.issue_valid_i   = 1'b0;
    sb.issue_rs1_i     = '0;
    sb.issue_rs2_i     = '0;
    sb.issue_use_rs1_i = 1'b0;
    sb.issue_use_rs2_i = 1'b0;
    sb.issue_rd_i      = '0;
    sb.issue_we_i      = 1'b0;
    sb.wb_valid_i      = 1'b0;
    sb.wb_rd_i         = '0;
    sb.wb_we_i         = 1'b0;
    sb.kill_valid_i    = '0;
    sb.kill_rd_i       = '0;
    sb.kill_we_i       = '0;
  endtask

  task automatic iss(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2, logic [4:0] rd, logic we);
    sb.issue_valid_i   = 1'b1;
    sb.issue_rs1_i     = rs1;
    sb.issue_use_rs1_i = u1;
    sb.issue_rs2_i     = rs2;
    sb.issue_use_rs2_i = u2;
    sb.issue_rd_i      = rd;
    sb.issue_we_i      = we;
  endtask

  task automatic wb(logic [4:0] rd, logic we);
    sb.wb_valid_i = 1'b1;
    sb.wb_rd_i    = rd;
    sb.wb_we_i    = we;
  endtask

  task automatic kill(logic [1:0] v, logic [4:0] rd1, logic [4:0] rd0, logic [1:0] we);
    sb.kill_valid_i = v;
    sb.kill_rd_i    = {rd1, rd0};
    sb.kill_we_i    = we;
  endtask

  // Record the expected response for the inputs just applied, then move to the next cycle
  task automatic go(string nm, logic es, logic ef, logic [31:0] eb, logic eu);
    exp_t e;
    e.nm = nm; e.stall = es; e.fire = ef; e.busy = eb; e.uf = eu;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  localparam logic [31:0] B3 = 32'h1 << 3;
  localparam logic [31:0] B4 = 32'h1 << 4;
  localparam logic [31:0] B5 = 32'h1 << 5;
  localparam logic [31:0] B6 = 32'h1 << 6;
  localparam logic [31:0] B7 = 32'h1 << 7;
  localparam logic [31:0] B8 = 32'h1 << 8;

  initial begin
    rstn = 1'b1;
    idle();
    #3 rstn = 1'b0;
    @(posedge clk);
    #1;

    iss(0, 0, 0, 0, 5, 1);              go("in_reset",     0, 1, 0, 0);
    rstn = 1'b1;
    iss(0, 0, 0, 0, 5, 1);              go("issue_r5",     0, 1, 0, 0);
    iss(5, 1, 0, 0, 0, 0);              go("raw_r5",       1, 0, B5, 0);
    iss(5, 1, 0, 0, 0, 0); wb(5, 1);    go("bypass_r5",    0, 1, B5, 0);
    iss(0, 0, 0, 0, 7, 1);              go("r7_first",     0, 1, 0, 0);
    iss(0, 0, 0, 0, 7, 1);              go("r7_second",    0, 1, B7, 0);
    iss(0, 0, 0, 0, 7, 1);              go("r7_third",     0, 1, B7, 0);
    iss(0, 0, 0, 0, 7, 1);              go("r7_sat",       1, 0, B7, 0);
    iss(0, 0, 0, 0, 7, 1); wb(7, 1);    go("r7_sat_wb",    0, 1, B7, 0);
    iss(0, 0, 0, 0, 7, 1);              go("r7_still3",    1, 0, B7, 0);
    wb(7, 1);                           go("r7_wb_to2",    0, 0, B7, 0);
    iss(0, 0, 7, 1, 0, 0); wb(7, 1);    go("no_byp_cnt2",  1, 0, B7, 0);
    iss(0, 0, 7, 1, 0, 0); kill(2'b01, 0, 7, 2'b01);
                                        go("kill_no_byp",  1, 0, B7, 0);
    iss(0, 0, 0, 0, 3, 1);              go("issue_r3",     0, 1, 0, 0);
    iss(0, 0, 0, 0, 4, 1);              go("issue_r4",     0, 1, B3, 0);
    kill(2'b11, 4, 3, 2'b11);           go("kill_both",    0, 0, B3 | B4, 0);
                                        go("after_kill",   0, 0, 0, 0);
    iss(0, 1, 0, 0, 0, 1);              go("r0_issue",     0, 1, 0, 0);
                                        go("r0_untracked", 0, 0, 0, 0);
    iss(0, 0, 0, 0, 6, 1);              go("r6_first",     0, 1, 0, 0);
    iss(0, 0, 0, 0, 6, 1);              go("r6_second",    0, 1, B6, 0);
    wb(6, 1); kill(2'b10, 6, 0, 2'b10); go("r6_wb_kill",   0, 0, B6, 0);
                                        go("r6_clear",     0, 0, 0, 0);
    wb(9, 1);                           go("wb_r9_empty",  0, 0, 0, 0);
                                        go("uf_set",       0, 0, 0, 1);
                                        go("uf_sticky",    0, 0, 0, 1);
    iss(0, 0, 0, 0, 2, 0); wb(3, 0); kill(2'b11, 4, 3, 2'b00);
                                        go("we0_events",   0, 1, 0, 1);
    iss(0, 0, 0, 0, 8, 1);              go("issue_r8",     0, 1, 0, 1);
    rstn = 1'b0;                        go("async_reset",  0, 0, 0, 0);
    rstn = 1'b1;                        go("post_reset",   0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the in-order pipeline.
- Replaces fixed per-stage rd comparisons with per-register pending-write counters, so it works with any pipeline depth and any variable-latency execute unit.
- Sits at decode: fed by the issue (decode->exe), writeback and kill (branch flush) events. Drives the decode stall.

Parameters:
- NUM_REGS, 32: number of architectural registers. Register 0 is hardwired zero and never tracked.
- ADDR_W, $clog2(NUM_REGS): register address width.
- CNT_W, 2: pending-counter width. Saturation point is 2**CNT_W-1 in-flight writers per register.
- KILL_PORTS, 2: number of kill lanes that can squash in-flight writers in one cycle.
- WB_BYPASS, 1: 1 = a register whose last pending write retires this cycle is not a hazard (regfile write-through).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  decode holds a valid instruction requesting issue
- issue_rs1_i  in  ADDR_W  source 1 address
- issue_rs2_i  in  ADDR_W  source 2 address
- issue_use_rs1_i  in  1  instruction reads rs1
- issue_use_rs2_i  in  1  instruction reads rs2
- issue_rd_i  in  ADDR_W  destination address
- issue_we_i  in  1  instruction writes rd
- wb_valid_i  in  1  writeback of an instruction that was issued
- wb_rd_i  in  ADDR_W  writeback destination
- wb_we_i  in  1  writeback writes rd
- kill_valid_i  in  KILL_PORTS  per-lane squash of an issued, not-yet-written-back instruction
- kill_rd_i  in  KILL_PORTS*ADDR_W  per-lane rd, lane k at bits [k*ADDR_W +: ADDR_W]
- kill_we_i  in  KILL_PORTS  per-lane write enable of the killed instruction
- stall_o  out  1  decode must hold; issue not accepted
- issue_fire_o  out  1  issue accepted this cycle
- busy_o  out  NUM_REGS  bit r = counter[r] != 0 (registered state)
- underflow_o  out  1  sticky error: a decrement hit a zero counter

Behaviour:
- State: counter[r], CNT_W bits, for r = 1..NUM_REGS-1. Counter 0 is constant 0.
- Reset (async, rstn_i low): all counters = 0, underflow_o = 0. Combinational outputs then give stall_o = 0, busy_o = 0, issue_fire_o = issue_valid_i.
- Decrement events in a cycle, counted per register:
  - wb: wb_valid_i & wb_we_i & wb_rd_i != 0.
  - kill lane k: kill_valid_i[k] & kill_we_i[k] & kill_rd_i[k] != 0.
  - dec[r] = number of events hitting r (0..KILL_PORTS+1).
- Hazard on source s (rs1 or rs2): use_s & rs_s != 0 & counter[rs_s] != 0.
  - Exception, WB_BYPASS=1: not a hazard if counter[rs_s] == 1 and the wb event targets rs_s this cycle.
  - Kills never bypass a hazard.
- Saturation: sat = issue_we_i & issue_rd_i != 0 & counter[issue_rd_i] == max & dec[issue_rd_i] == 0.
- stall_o = issue_valid_i & (hazard_rs1 | hazard_rs2 | sat). Purely combinational, zero latency.
- issue_fire_o = issue_valid_i & ~stall_o.
- inc[r] = issue_fire_o & issue_we_i & issue_rd_i == r & r != 0.
- Next state: counter[r] <= counter[r] + inc[r] - dec[r], in CNT_W+2-bit arithmetic.
  - Same-cycle issue and retire on one register nets out, e.g. count 1, +1 -1 -> 1.
- If dec[r] > counter[r] + inc[r]: counter[r] <= 0 and underflow_o <= 1. underflow_o stays 1 until reset.
- Overflow cannot occur: sat blocks issue at max.
- WAW hazards are not stalls; the counters track multiple writers. The pipeline guarantees in-order writeback.
- Kill and issue in the same cycle are independent. The caller gates issue_valid_i on a flush.
- Events with we = 0, or rd = 0, have no effect.
- Reset mid-operation clears all pending state immediately. Later wb/kill events for pre-reset instructions set underflow_o (caller responsibility).

Test Plan:
- Reset, then issue rd=5 with we=1 -> issue_fire_o=1; next cycle busy_o[5]=1, counter[5]=1.
- With counter[5]=1, issue rs1=5 with use_rs1=1 -> stall_o=1. Same with wb rd=5 in that cycle and WB_BYPASS=1 -> stall_o=0, issue_fire_o=1, counter[5]=0 next cycle.
- Issue three writers to rd=7 back-to-back (CNT_W=2) -> counter 1,2,3. Fourth issue to rd=7 -> stall_o=1. Fourth issue with a wb on rd=7 in the same cycle -> fires, counter stays 3.
- Counters: r3=1, r4=1. Pulse kill_valid_i=2'b11 with rd {4,3} -> both clear next cycle, busy_o=0, underflow_o=0.
- Issue rs1=0, rd=0, with we=1 -> never stalls; counter unchanged; busy_o[0]=0.
- wb rd=9 with counter[9]=0 -> underflow_o=1 and remains 1. Async reset asserted mid-cycle -> underflow_o=0 and busy_o=0 immediately.
